// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream beat/ready plus downstream head/ready.
// The slave modport is the buffer's view; master is the environment driving it.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 48,
    parameter int CTRL_W = 16
);
    logic              inValid;
    logic [DATA_W-1:0] inData;
    logic [CTRL_W-1:0] inCtrl;
    logic              bubble;
    logic              flush;
    logic              outReady;
    logic              inReady;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic [CTRL_W-1:0] outCtrl;

    modport master (
        output inValid, inData, inCtrl, bubble, flush, outReady,
        input  inReady, outValid, outData, outCtrl
    );

    modport slave (
        input  inValid, inData, inCtrl, bubble, flush, outReady,
        output inReady, outValid, outData, outCtrl
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry (head + skid) pipeline stage buffer with bubble insertion, flush with
// saturating drop counter, and sticky detection of upstream valid/data retraction.
module pipe_stage_buf #(
    parameter int DATA_W = 48,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_buf_if.slave  bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] dropCount,
    output logic             err
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HEAD  = 2'd1,
        BOTH  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt, skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
    logic [CTRL_W-1:0] in_ctrl_eff;
    logic              accept, emit;
    logic [1:0]        drop_n;
    logic [CNT_W:0]    drop_sum;
    logic              prev_stall, prev_flush, err_set;
    logic [DATA_W-1:0] prev_data;
    logic [CTRL_W-1:0] prev_ctrl;

    assign bus.inReady  = (state != BOTH) && !rst;
    assign bus.outValid = (state != EMPTY);
    assign bus.outData  = head_data;
    assign bus.outCtrl  = bus.outValid ? head_ctrl : '0;

    assign accept      = bus.inValid & bus.inReady;
    assign emit        = bus.outValid & bus.outReady;
    assign in_ctrl_eff = bus.bubble ? '0 : bus.inCtrl;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            HEAD:    occupancy = 2'd1;
            BOTH:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        head_data_nxt = head_data;
        head_ctrl_nxt = head_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        drop_n        = 2'd0;
        if (bus.flush) begin
            // Same-cycle input is dropped; an emitted head is delivered, not dropped.
            state_nxt = EMPTY;
            case (state)
                HEAD:    drop_n = emit ? 2'd0 : 2'd1;
                BOTH:    drop_n = emit ? 2'd1 : 2'd2;
                default: drop_n = 2'd0;
            endcase
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_data_nxt = bus.inData;
                        head_ctrl_nxt = in_ctrl_eff;
                        state_nxt     = HEAD;
                    end
                end
                HEAD: begin
                    if (accept && emit) begin
                        head_data_nxt = bus.inData;
                        head_ctrl_nxt = in_ctrl_eff;
                    end else if (accept) begin
                        skid_data_nxt = bus.inData;
                        skid_ctrl_nxt = in_ctrl_eff;
                        state_nxt     = BOTH;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
                BOTH: begin
                    if (emit) begin
                        head_data_nxt = skid_data;
                        head_ctrl_nxt = skid_ctrl;
                        state_nxt     = HEAD;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign drop_sum = {1'b0, dropCount} + (CNT_W+1)'(drop_n);

    // A stalled beat must be held unchanged until accepted, unless a flush intervenes.
    assign err_set = prev_stall && !prev_flush && !bus.flush &&
                     (!bus.inValid || (bus.inData != prev_data) || (bus.inCtrl != prev_ctrl));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            head_data  <= '0;
            head_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            dropCount  <= '0;
            err        <= 1'b0;
            prev_stall <= 1'b0;
            prev_flush <= 1'b0;
            prev_data  <= '0;
            prev_ctrl  <= '0;
        end else begin
            state      <= state_nxt;
            head_data  <= head_data_nxt;
            head_ctrl  <= head_ctrl_nxt;
            skid_data  <= skid_data_nxt;
            skid_ctrl  <= skid_ctrl_nxt;
            dropCount  <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            err        <= err | err_set;
            prev_stall <= bus.inValid & ~bus.inReady;
            prev_flush <= bus.flush;
            prev_data  <= bus.inData;
            prev_ctrl  <= bus.inCtrl;
        end
    end
endmodule
